// File: rtl/program_sequencer_if.sv
// Sequencing bus between the control unit (master) and the program sequencer (slave).
// The SEQ_IRQ_EN macro adds the irq request and in_isr status signals.
interface program_sequencer_if #(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 8
);
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  logic            stall;
  logic [2:0]      op;
  logic [PC_W-1:0] target;
  logic            z;
  logic [PC_W-1:0] pc;
  logic [SP_W-1:0] sp;
  logic            stack_full;
  logic            stack_empty;
  logic            overflow;
  logic            underflow;
`ifdef SEQ_IRQ_EN
  logic            irq;
  logic            in_isr;
`endif

  modport master (
    output stall, op, target, z,
`ifdef SEQ_IRQ_EN
    output irq,
    input  in_isr,
`endif
    input  pc, sp, stack_full, stack_empty, overflow, underflow
  );

  modport slave (
    input  stall, op, target, z,
`ifdef SEQ_IRQ_EN
    input  irq,
    output in_isr,
`endif
    output pc, sp, stack_full, stack_empty, overflow, underflow
  );
endinterface

// File: rtl/program_sequencer.sv
// Program counter, branch/jump selection and return-address stack for the single-cycle core.
// Optional interrupt entry is enabled by defining SEQ_IRQ_EN.
module program_sequencer #(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 8,
  parameter int RESET_ADDR  = 0,
  parameter int IRQ_VECTOR  = 1
) (
  input  logic              clk,
  input  logic              reset,
  program_sequencer_if.slave bus
);
  localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam logic [PC_W-1:0] RESET_PC = PC_W'(RESET_ADDR);
  localparam logic [SP_W-1:0] FULL_SP  = SP_W'(STACK_DEPTH);

  if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0 ||
      RESET_ADDR < 0 || IRQ_VECTOR < 0) begin : g_bad_params
    $error("program_sequencer: STACK_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    OP_INC  = 3'b000,
    OP_JMP  = 3'b001,
    OP_JREL = 3'b010,
    OP_CALL = 3'b011,
    OP_RET  = 3'b100,
    OP_BZ   = 3'b101,
    OP_BNZ  = 3'b110,
    OP_RSV  = 3'b111
  } op_t;

  op_t             op_dec;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [SP_W-1:0] sp_reg, sp_next;
  logic            overflow_reg, overflow_next;
  logic            underflow_reg, underflow_next;
  logic [PC_W-1:0] pc_inc;
  logic [SP_W-1:0] sp_inc, sp_dec;
  logic [IDX_W-1:0] push_idx, pop_idx;
  logic            full, empty;
  logic            push;
  logic [PC_W-1:0] push_data;
  logic [PC_W-1:0] stack_mem [STACK_DEPTH];
  logic [PC_W-1:0] tos;

  assign op_dec   = op_t'(bus.op);
  assign pc_inc   = pc_reg + 1'b1;
  assign sp_inc   = sp_reg + 1'b1;
  assign sp_dec   = sp_reg - 1'b1;
  // Pushes only happen when not full, so sp itself fits the index width.
  assign push_idx = sp_reg[IDX_W-1:0];
  assign pop_idx  = sp_dec[IDX_W-1:0];
  assign full     = (sp_reg == FULL_SP);
  assign empty    = (sp_reg == '0);
  assign tos      = stack_mem[pop_idx];

`ifdef SEQ_IRQ_EN
  localparam logic [PC_W-1:0] IRQ_PC = PC_W'(IRQ_VECTOR);
  logic in_isr_reg, in_isr_next;
  logic irq_take;
  assign irq_take = bus.irq && !in_isr_reg && !full;
`endif

  always_comb begin
    pc_next        = pc_reg;
    sp_next        = sp_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    push           = 1'b0;
    push_data      = pc_inc;
`ifdef SEQ_IRQ_EN
    in_isr_next    = in_isr_reg;
`endif
    if (!bus.stall) begin
`ifdef SEQ_IRQ_EN
      // The interrupted instruction is re-fetched on return, so push pc, not pc+1.
      if (irq_take) begin
        push        = 1'b1;
        push_data   = pc_reg;
        pc_next     = IRQ_PC;
        sp_next     = sp_inc;
        in_isr_next = 1'b1;
      end else
`endif
      begin
        case (op_dec)
          OP_JMP:  pc_next = bus.target;
          OP_JREL: pc_next = pc_reg + bus.target;
          OP_BZ:   pc_next = bus.z ? bus.target : pc_inc;
          OP_BNZ:  pc_next = bus.z ? pc_inc : bus.target;
          OP_CALL: begin
            if (full) begin
              pc_next       = pc_inc;
              overflow_next = 1'b1;
            end else begin
              push    = 1'b1;
              pc_next = bus.target;
              sp_next = sp_inc;
            end
          end
          OP_RET: begin
            if (empty) begin
              pc_next        = pc_inc;
              underflow_next = 1'b1;
            end else begin
              pc_next = tos;
              sp_next = sp_dec;
            end
`ifdef SEQ_IRQ_EN
            in_isr_next = 1'b0;
`endif
          end
          default: pc_next = pc_inc;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg        <= RESET_PC;
      sp_reg        <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
`ifdef SEQ_IRQ_EN
      in_isr_reg    <= 1'b0;
`endif
    end else begin
      pc_reg        <= pc_next;
      sp_reg        <= sp_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
`ifdef SEQ_IRQ_EN
      in_isr_reg    <= in_isr_next;
`endif
    end
  end

  // Stack storage has no reset; an empty stack is defined purely by sp.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      stack_mem[push_idx] <= push_data;
    end
  end

  assign bus.pc          = pc_reg;
  assign bus.sp          = sp_reg;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.overflow    = overflow_reg;
  assign bus.underflow   = underflow_reg;
`ifdef SEQ_IRQ_EN
  assign bus.in_isr      = in_isr_reg;
`endif
endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Parametrised program-counter and sequencing unit for the next single-cycle core.
- Replaces the fixed 10-bit PC register, PC adder, jump muxes and subroutine stack of the current datapath with one block.
- Adds conditional branches, signed relative jumps, stack full/empty detection, sticky error flags and a stall input.
- Drives the program-memory address and receives the decoded sequencing op from the control unit.

Parameters:
PC_W, 10, program counter / address width in bits
STACK_DEPTH, 8, number of return-address entries (power of two, >= 2)
RESET_ADDR, 0, PC value loaded on reset
IRQ_VECTOR, 1, PC loaded when an interrupt is taken (used only with SEQ_IRQ_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  1 = hold all state this cycle
op  in  3  sequencing op: 000 INC, 001 JMP, 010 JREL, 011 CALL, 100 RET, 101 BZ, 110 BNZ, 111 INC (reserved)
target  in  PC_W  absolute target (JMP/CALL/BZ/BNZ) or signed two's-complement offset (JREL)
z  in  1  zero flag from the flag flip-flop
pc  out  PC_W  current program address
sp  out  clog2(STACK_DEPTH)+1  number of valid stack entries
stack_full  out  1  sp == STACK_DEPTH
stack_empty  out  1  sp == 0
overflow  out  1  sticky: CALL attempted while full
underflow  out  1  sticky: RET attempted while empty

Behaviour:
- Reset: asynchronous, active-high. pc=RESET_ADDR; sp=0; overflow=0; underflow=0. Stack array contents are not reset.
- All other updates occur on the rising edge of clk. pc is registered; the new value is visible 1 cycle after op is presented.
- stall=1: pc, sp, flags and stack are unchanged regardless of op. stall has priority over every op.
- INC / reserved: pc <= pc+1, modulo 2^PC_W (wraps from all-ones to 0).
- JMP: pc <= target.
- JREL: pc <= pc + target, with target sign-interpreted and the result modulo 2^PC_W. A backward offset past 0 wraps.
- BZ: pc <= target if z=1, else pc+1.
- BNZ: pc <= target if z=0, else pc+1.
- CALL, not full: stack[sp] <= pc+1 (wrapped); sp <= sp+1; pc <= target.
- CALL, full: no push; sp unchanged; pc <= pc+1; overflow <= 1.
- RET, not empty: pc <= stack[sp-1]; sp <= sp-1.
- RET, empty: pc <= pc+1; underflow <= 1.
- overflow and underflow clear only on reset.
- stack_full and stack_empty are combinational from sp.
- Depth-1 corner: CALL then RET returns to the pushed address even when sp reaches STACK_DEPTH.
- Reset asserted mid-operation (any op, any sp) wins immediately. The stack is logically emptied via sp=0.

Optional Feature:
- Macro: SEQ_IRQ_EN.
- Defined: adds input irq (1 bit) and output in_isr (1 bit, reset 0).
  - When irq=1, in_isr=0, stall=0 and the stack is not full, op is ignored that cycle. The block pushes the current pc (the unexecuted instruction is re-fetched after return), sets pc <= IRQ_VECTOR, sp <= sp+1 and in_isr <= 1.
  - irq is ignored while in_isr=1 or while the stack is full.
  - A RET executed while in_isr=1 also clears in_isr.
- Not defined: no irq or in_isr ports; behaviour is exactly as above.

Test Plan:
1. Reset, then 3 cycles of INC -> pc goes 0,1,2,3. With PC_W=10 and pc=1023, INC -> pc=0.
2. pc=20, JREL target=10'h3FB (-5) -> pc=15. pc=2, JREL target=-5 -> pc=1021.
3. pc=40, z=1: BZ target=100 -> pc=100. Repeat with z=0 -> pc=41. BNZ with z=0, target=7 -> pc=7.
4. pc=5, CALL 50 -> pc=50, sp=1. Then CALL 80 -> pc=80, sp=2. RET -> pc=51, sp=1. RET -> pc=6, sp=0, stack_empty=1.
5. Issue 8 CALLs to fill the stack, then a 9th CALL at pc=P -> pc=P+1, sp=8, overflow=1. On an empty stack, RET -> underflow=1 and pc increments. Both flags stay set until reset is pulsed.
6. stall=1 with op=CALL -> no change to pc or sp. Assert reset asynchronously mid-cycle with sp=3 -> pc=RESET_ADDR and sp=0 immediately, without waiting for a clock edge. With SEQ_IRQ_EN: irq at pc=30 -> pc=IRQ_VECTOR, in_isr=1; RET -> pc=30, in_isr=0.
